// File: rtl/mioc_dram_seq.sv
// DRAM strobe sequencer for the Z80 memory I/O controller.
// Generates RAS/MUX/CAS for CPU accesses, RAS-only cycles for Z80 refresh,
// and a timer-driven hidden refresh with CPU wait insertion.
module mioc_dram_seq (
  input  logic B_PHI,
  input  logic RST_N,
  input  logic BMREQ_N,
  input  logic BRD_N,
  input  logic N_BWR,
  input  logic BRFSH_N,
  input  logic BUSAK_N,
  input  logic RAM_HIT,
  input  logic BANK,
  output logic RAS_N,
  output logic MUX,
  output logic CAS1_N,
  output logic CAS2_N,
  output logic WAIT_N,
  output logic RFSH_ACT
);

  localparam int unsigned TMR_W = 6;
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(63);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ROW   = 3'd1,
    S_COL   = 3'd2,
    S_HOLD  = 3'd3,
    S_RFSH  = 3'd4,
    S_HRFSH = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic             bank_q, bank_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             pend_q, pend_d;
  logic             hcnt_q, hcnt_d;
  logic             ras_n_q, ras_n_d;
  logic             mux_q, mux_d;
  logic             cas1_n_q, cas1_n_d;
  logic             cas2_n_q, cas2_n_d;
  logic             wait_n_q, wait_n_d;
  logic             rfsh_act_q, rfsh_act_d;
  logic             acc_req;
  logic             z80_rfsh;
  logic             rfsh_entry;
  logic             hrfsh_exit;

  // Decode CPU access and Z80 refresh requests from the buffered bus
  always_comb begin
    acc_req  = !BMREQ_N && RAM_HIT && BRFSH_N && (!BRD_N || !N_BWR);
    z80_rfsh = !BMREQ_N && !BRFSH_N;
  end

  // Next-state logic: hidden refresh beats Z80 refresh beats a new access
  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    hcnt_d  = hcnt_q;
    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          state_d = S_HRFSH;
          hcnt_d  = 1'b0;
        end else if (z80_rfsh) begin
          state_d = S_RFSH;
        end else if (acc_req) begin
          state_d = S_ROW;
          bank_d  = BANK;
        end
      end
      S_ROW: begin
        state_d = BMREQ_N ? S_IDLE : S_COL;
      end
      S_COL: begin
        state_d = BMREQ_N ? S_IDLE : S_HOLD;
      end
      S_HOLD: begin
        if (BMREQ_N) state_d = S_IDLE;
      end
      S_RFSH: begin
        if (BMREQ_N || BRFSH_N) state_d = S_IDLE;
      end
      S_HRFSH: begin
        hcnt_d = 1'b1;
        if (hcnt_q) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Refresh timer and pending flag; any refresh entry restarts the interval
  always_comb begin
    rfsh_entry = (state_d != state_q) && ((state_d == S_RFSH) || (state_d == S_HRFSH));
    hrfsh_exit = (state_q == S_HRFSH) && (state_d == S_IDLE);
    tmr_d      = tmr_q;
    if (rfsh_entry) begin
      tmr_d = '0;
    end else if (!BUSAK_N && (tmr_q != TMR_MAX)) begin
      tmr_d = tmr_q + TMR_W'(1);
    end
    pend_d = pend_q;
    if (hrfsh_exit) begin
      pend_d = 1'b0;
    end else if (tmr_d == TMR_MAX) begin
      pend_d = 1'b1;
    end
  end

  // Output values for the cycle after the edge, derived from the next state
  always_comb begin
    ras_n_d    = (state_d == S_IDLE);
    mux_d      = (state_d == S_COL) || (state_d == S_HOLD);
    cas1_n_d   = !((state_d == S_HOLD) && !bank_d);
    cas2_n_d   = !((state_d == S_HOLD) && bank_d);
    rfsh_act_d = (state_d == S_HRFSH);
    // Stall the CPU while a hidden refresh owns the array, released on access start
    wait_n_d   = !(acc_req && ((state_d == S_HRFSH) || (state_q == S_HRFSH)));
  end

  // State, timer and registered output flops
  always_ff @(posedge B_PHI or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      bank_q     <= 1'b0;
      tmr_q      <= '0;
      pend_q     <= 1'b0;
      hcnt_q     <= 1'b0;
      ras_n_q    <= 1'b1;
      mux_q      <= 1'b0;
      cas1_n_q   <= 1'b1;
      cas2_n_q   <= 1'b1;
      wait_n_q   <= 1'b1;
      rfsh_act_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bank_q     <= bank_d;
      tmr_q      <= tmr_d;
      pend_q     <= pend_d;
      hcnt_q     <= hcnt_d;
      ras_n_q    <= ras_n_d;
      mux_q      <= mux_d;
      cas1_n_q   <= cas1_n_d;
      cas2_n_q   <= cas2_n_d;
      wait_n_q   <= wait_n_d;
      rfsh_act_q <= rfsh_act_d;
    end
  end

  assign RAS_N    = ras_n_q;
  assign MUX      = mux_q;
  assign CAS1_N   = cas1_n_q;
  assign CAS2_N   = cas2_n_q;
  assign WAIT_N   = wait_n_q;
  assign RFSH_ACT = rfsh_act_q;

endmodule

// File: tb/tb_mioc_dram_seq.sv
// Scoreboard bench for mioc_dram_seq: the driver queues the expected output
// vector for each edge, the monitor compares it just after that edge.
module tb_mioc_dram_seq;

  logic B_PHI, RST_N;
  logic BMREQ_N, BRD_N, N_BWR, BRFSH_N, BUSAK_N, RAM_HIT, BANK;
  logic RAS_N, MUX, CAS1_N, CAS2_N, WAIT_N, RFSH_ACT;

  // Output vectors {RAS_N,MUX,CAS1_N,CAS2_N,WAIT_N,RFSH_ACT}
  localparam logic [5:0] O_IDLE  = 6'b101110;
  localparam logic [5:0] O_IDLEW = 6'b101100;
  localparam logic [5:0] O_ROW   = 6'b001110;
  localparam logic [5:0] O_COL   = 6'b011110;
  localparam logic [5:0] O_H0    = 6'b010110;
  localparam logic [5:0] O_H1    = 6'b011010;
  localparam logic [5:0] O_RF    = 6'b001110;
  localparam logic [5:0] O_HRF   = 6'b001111;
  localparam logic [5:0] O_HRFW  = 6'b001101;

  // Input vectors {BMREQ_N,BRD_N,N_BWR,BRFSH_N,BUSAK_N,RAM_HIT,BANK}
  localparam logic [6:0] I_IDLE    = 7'b1111100;
  localparam logic [6:0] I_IDLE_BL = 7'b1111000;
  localparam logic [6:0] I_RD0     = 7'b0011110;
  localparam logic [6:0] I_RD0_BL  = 7'b0011010;
  localparam logic [6:0] I_RD_MISS = 7'b0011100;
  localparam logic [6:0] I_WR1     = 7'b0101111;
  localparam logic [6:0] I_WR_TGL  = 7'b0101100;
  localparam logic [6:0] I_RF      = 7'b0010110;
  localparam logic [6:0] I_MREQ    = 7'b0111110;

  typedef struct {
    int unsigned cyc;
    logic [5:0]  exp;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          total;
  int          bad;
  int unsigned cyc_cnt;

  mioc_dram_seq dut (
    .B_PHI   (B_PHI),
    .RST_N   (RST_N),
    .BMREQ_N (BMREQ_N),
    .BRD_N   (BRD_N),
    .N_BWR   (N_BWR),
    .BRFSH_N (BRFSH_N),
    .BUSAK_N (BUSAK_N),
    .RAM_HIT (RAM_HIT),
    .BANK    (BANK),
    .RAS_N   (RAS_N),
    .MUX     (MUX),
    .CAS1_N  (CAS1_N),
    .CAS2_N  (CAS2_N),
    .WAIT_N  (WAIT_N),
    .RFSH_ACT(RFSH_ACT)
  );

  initial B_PHI = 1'b0;
  always #5 B_PHI = ~B_PHI;

  always @(posedge B_PHI) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [5:0] obs();
    return {RAS_N, MUX, CAS1_N, CAS2_N, WAIT_N, RFSH_ACT};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [6:0] v);
    {BMREQ_N, BRD_N, N_BWR, BRFSH_N, BUSAK_N, RAM_HIT, BANK} = v;
  endtask

  task automatic step(input logic [6:0] v, input logic [5:0] e, input string nm);
    @(negedge B_PHI);
    drive(v);
    sb.push_back('{cyc_cnt + 1, e, nm});
    @(posedge B_PHI);
  endtask

  // Monitor: pop and compare every expectation due at this edge
  initial begin
    exp_t e;
    forever begin
      @(posedge B_PHI);
      #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
        e = sb.pop_front();
        if (e.cyc < cyc_cnt) check({e.name, "_late"}, cyc_cnt, e.cyc);
        else                 check(e.name, obs(), e.exp);
      end
      check("cas_excl", 32'(!CAS1_N && !CAS2_N), 0);
      check("cas_no_ras", 32'((!CAS1_N || !CAS2_N) && RAS_N), 0);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total   = 0;
    bad     = 0;
    cyc_cnt = 0;
    RST_N   = 1'b0;
    drive(I_IDLE);
    #12;
    check("rst_out", obs(), O_IDLE);
    check("rst_tmr", dut.tmr_q, 0);
    @(negedge B_PHI);
    RST_N = 1'b1;
    step(I_IDLE, O_IDLE, "idle0");
    step(I_RD_MISS, O_IDLE, "rd_no_hit");

    // Read bank 0
    step(I_RD0, O_ROW, "rd0_row");
    step(I_RD0, O_COL, "rd0_col");
    step(I_RD0, O_H0, "rd0_hold");
    step(I_RD0, O_H0, "rd0_hold2");
    step(I_IDLE, O_IDLE, "rd0_end");
    step(I_IDLE, O_IDLE, "rd0_idle");

    // Write bank 1 with BANK and RAM_HIT changing after the start edge
    step(I_WR1, O_ROW, "wr1_row");
    step(I_WR_TGL, O_COL, "wr1_col");
    step(I_WR_TGL, O_H1, "wr1_hold");
    step(I_WR_TGL, O_H1, "wr1_hold2");
    step(I_IDLE, O_IDLE, "wr1_end");

    // Abort in ROW and in COL
    step(I_RD0, O_ROW, "ab_row");
    step(I_IDLE, O_IDLE, "ab_row_exit");
    step(I_IDLE, O_IDLE, "ab_row_idle");
    step(I_RD0, O_ROW, "ab2_row");
    step(I_RD0, O_COL, "ab2_col");
    step(I_IDLE, O_IDLE, "ab2_exit");

    // Z80 refresh with a read also asserted; exit on BRFSH_N high
    step(I_RF, O_RF, "rf_enter");
    step(I_RF, O_RF, "rf_hold");
    step(I_MREQ, O_IDLE, "rf_exit");
    step(I_IDLE, O_IDLE, "rf_idle");

    // Hidden refresh after 64 clocks of BUSAK_N low, read arrives in HRFSH
    for (int i = 1; i <= 63; i++) step(I_IDLE_BL, O_IDLE, "hid_count");
    step(I_IDLE_BL, O_HRF, "hrf_c1");
    step(I_RD0_BL, O_HRFW, "hrf_c2_wait");
    step(I_RD0_BL, O_IDLEW, "hrf_exit_wait");
    step(I_RD0_BL, O_ROW, "hrf_acc_row");
    step(I_RD0_BL, O_COL, "hrf_acc_col");
    step(I_RD0_BL, O_H0, "hrf_acc_hold");
    step(I_IDLE, O_IDLE, "hrf_acc_end");
    #1;
    check("tmr_hold", dut.tmr_q, 5);

    // Reset asserted during HOLD with CAS1_N low
    step(I_RD0_BL, O_ROW, "rst_acc_row");
    step(I_RD0_BL, O_COL, "rst_acc_col");
    step(I_RD0_BL, O_H0, "rst_acc_hold");
    #2;
    RST_N = 1'b0;
    drive(I_RD0);
    #1;
    check("rst_mid_out", obs(), O_IDLE);
    check("rst_mid_tmr", dut.tmr_q, 0);
    @(negedge B_PHI);
    RST_N = 1'b1;
    sb.push_back('{cyc_cnt + 1, O_ROW, "post_rst_row"});
    @(posedge B_PHI);
    step(I_RD0, O_COL, "post_rst_col");
    step(I_RD0, O_H0, "post_rst_hold");
    step(I_IDLE, O_IDLE, "post_rst_end");

    repeat (3) @(posedge B_PHI);
    #2;
    check("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
